affine_loop_controller: RTL and testbench

- Upstream control stage for the unified buffers: walks a 3-D affine iteration domain and drives per-port `*_wen`/`*_ren` strobes plus `ctrl_vars[2:0]`.
- One instance per buffer port, e.g. the writer of `hw_input_global_wrapper_stencil` and the reader of `mult_stencil`.
- Loop order is fixed: dim1 is innermost, then dim2, then dim0 outermost. This matches buffer addressing `ctrl[1] + 64*ctrl[2]`.

---
 rtl/affine_loop_controller_pkg.sv | 14 +
 rtl/affine_loop_controller_if.sv | 14 +
 rtl/affine_loop_controller_counter.sv | 29 ++
 rtl/affine_loop_controller.sv | 129 ++++++++++++
 tb/tb_affine_loop_controller.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/affine_loop_controller_pkg.sv
// Shared types for the affine loop controller: FSM state encoding, index type, dimension count.
package affine_ctrl_pkg;
  localparam int CTRL_DIMS = 3;
  localparam int CTRL_W    = 16;

  typedef logic [CTRL_W-1:0] ctrl_var_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } ctrl_state_e;
endpackage

// File: rtl/affine_loop_controller_if.sv
// Control/strobe bundle between an affine loop controller (master) and its buffer port (slave).
interface affine_loop_controller_if import affine_ctrl_pkg::*; #(
  parameter int W = CTRL_W
) ();
  logic         flush;
  logic         en;
  logic         valid;
  logic [W-1:0] ctrl_vars [CTRL_DIMS-1:0];
  logic         busy;
  logic         done;

  modport master (input flush, en, output valid, ctrl_vars, busy, done);
  modport slave  (output flush, en, input valid, ctrl_vars, busy, done);
endinterface

// File: rtl/affine_loop_controller_counter.sv
// One cascaded loop index: counts 0..EXT-1 on i_inc, o_wrap flags the increment that returns it to 0.
module affine_ctrl_counter #(
  parameter int W   = 16,
  parameter int EXT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_idx,
  output logic         o_wrap
);
  localparam logic [W-1:0] LAST = W'(EXT - 1);

  logic [W-1:0] r_idx;

  assign o_wrap = i_inc && (r_idx == LAST);
  assign o_idx  = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= o_wrap ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/affine_loop_controller.sv
// Walks a 3-D affine domain (dim1 innermost, dim2, dim0 outer) and strobes valid per point.
// Optional AFFINE_LOOP_CONTROLLER_AUTORESTART_EN: restart after the last point, done becomes a pulse.
module affine_loop_controller import affine_ctrl_pkg::*; #(
  parameter int EXT0        = 1,
  parameter int EXT1        = 64,
  parameter int EXT2        = 64,
  parameter int START_DELAY = 0,
  parameter int II          = 1,
  parameter int W           = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  affine_loop_controller_if.master ctrl_if
);
  localparam int                IIW      = (II > 1) ? $clog2(II) : 1;
  localparam logic [IIW-1:0]    II_LAST  = IIW'(II - 1);
  localparam logic [15:0]       DLY_LAST = 16'(START_DELAY - 1);
  localparam ctrl_state_e       START_ST = (START_DELAY == 0) ? RUN : DELAY;
  localparam longint            IDX_SPAN = longint'(1) << W;

  if (EXT0 < 1 || EXT1 < 1 || EXT2 < 1 || longint'(EXT0) > IDX_SPAN ||
      longint'(EXT1) > IDX_SPAN || longint'(EXT2) > IDX_SPAN ||
      II < 1 || START_DELAY < 0 || START_DELAY > 65535) begin : g_bad_cfg
    $fatal(1, "affine_loop_controller: extent, II or START_DELAY out of range");
  end

  ctrl_state_e    r_state;
  logic [15:0]    r_dly_cnt;
  logic [IIW-1:0] r_ii_cnt;
  logic           r_valid;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_ctrl [CTRL_DIMS-1:0];
  logic [W-1:0]   w_idx  [CTRL_DIMS-1:0];
  logic           w_emit;
  logic           w_wrap0;
  logic           w_wrap1;
  logic           w_wrap2;
`ifdef AFFINE_LOOP_CONTROLLER_AUTORESTART_EN
  logic           r_fin;
`endif

  // A flush on the due cycle drops the point; counters then restart from zero.
  assign w_emit = (r_state == RUN) && ctrl_if.en && !ctrl_if.flush && (r_ii_cnt == '0);

  affine_ctrl_counter #(.W(W), .EXT(EXT1)) u_dim1 (
    .clk(clk), .rst_n(rst_n), .i_clr(ctrl_if.flush), .i_inc(w_emit),
    .o_idx(w_idx[1]), .o_wrap(w_wrap1)
  );
  affine_ctrl_counter #(.W(W), .EXT(EXT2)) u_dim2 (
    .clk(clk), .rst_n(rst_n), .i_clr(ctrl_if.flush), .i_inc(w_wrap1),
    .o_idx(w_idx[2]), .o_wrap(w_wrap2)
  );
  affine_ctrl_counter #(.W(W), .EXT(EXT0)) u_dim0 (
    .clk(clk), .rst_n(rst_n), .i_clr(ctrl_if.flush), .i_inc(w_wrap2),
    .o_idx(w_idx[0]), .o_wrap(w_wrap0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dly_cnt <= '0;
      r_ii_cnt  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int k = 0; k < CTRL_DIMS; k++) r_ctrl[k] <= '0;
`ifdef AFFINE_LOOP_CONTROLLER_AUTORESTART_EN
      r_fin     <= 1'b0;
`endif
    end else begin
      r_valid <= w_emit;
      for (int k = 0; k < CTRL_DIMS; k++) r_ctrl[k] <= w_emit ? w_idx[k] : '0;
`ifdef AFFINE_LOOP_CONTROLLER_AUTORESTART_EN
      r_fin  <= w_emit && w_wrap0;
      r_done <= r_fin;
`endif
      if (ctrl_if.flush) begin
        r_state   <= START_ST;
        r_dly_cnt <= '0;
        r_ii_cnt  <= '0;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;
          DELAY: begin
            if (ctrl_if.en) begin
              if (r_dly_cnt == DLY_LAST) begin
                r_state   <= RUN;
                r_dly_cnt <= '0;
              end else begin
                r_dly_cnt <= r_dly_cnt + 1'b1;
              end
            end
          end
          RUN: begin
            if (ctrl_if.en) begin
              if (r_ii_cnt == '0) begin
                r_ii_cnt <= II_LAST;
                // dim0 only wraps when every index wraps: this was the final point.
                if (w_wrap0) begin
`ifdef AFFINE_LOOP_CONTROLLER_AUTORESTART_EN
                  r_state  <= START_ST;
                  r_ii_cnt <= (START_DELAY == 0) ? II_LAST : '0;
`else
                  r_state  <= DONE;
`endif
                end
              end else begin
                r_ii_cnt <= r_ii_cnt - 1'b1;
              end
            end
          end
          DONE: begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ctrl_if.valid     = r_valid;
  assign ctrl_if.busy      = r_busy;
  assign ctrl_if.done      = r_done;
  assign ctrl_if.ctrl_vars = r_ctrl;
endmodule

// File: tb/tb_affine_loop_controller.sv
// Directed bench: default 64x64 walk, delayed/II=2 small walk, stall, mid-run flush, async reset.
module tb_affine_loop_controller;
  import affine_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  affine_loop_controller_if if_a ();
  affine_loop_controller_if if_b ();

  affine_loop_controller u_a (.clk(clk), .rst_n(rst_n), .ctrl_if(if_a));
  affine_loop_controller #(.EXT1(4), .EXT2(2), .START_DELAY(3), .II(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ctrl_if(if_b)
  );

  logic      s_valid, s_busy, s_done;
  ctrl_var_t s_c [CTRL_DIMS-1:0];

  always_comb begin
    s_valid = sel ? if_b.valid : if_a.valid;
    s_busy  = sel ? if_b.busy  : if_a.busy;
    s_done  = sel ? if_b.done  : if_a.done;
    for (int k = 0; k < CTRL_DIMS; k++) s_c[k] = sel ? if_b.ctrl_vars[k] : if_a.ctrl_vars[k];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic e);
    if (sel) begin
      if_b.flush = f;
      if_b.en    = e;
    end else begin
      if_a.flush = f;
      if_a.en    = e;
    end
  endtask

  task automatic chk_st(input string tag, input logic v, input logic b, input logic d);
    chk({tag, "_valid"}, 32'(s_valid), 32'(v));
    chk({tag, "_busy"},  32'(s_busy),  32'(b));
    chk({tag, "_done"},  32'(s_done),  32'(d));
  endtask

  // Point p of the walk, decoded as dim1 fastest, then dim2, then dim0.
  task automatic walk(input int p0, input int p1, input int ii, input int e1, input int e2,
                      input string tag);
    for (int p = p0; p <= p1; p++) begin
      step();
      chk($sformatf("%s_p%0d_v", tag, p),  32'(s_valid), 32'd1);
      chk($sformatf("%s_p%0d_d0", tag, p), 32'(s_c[0]), 32'(p / (e1 * e2)));
      chk($sformatf("%s_p%0d_d1", tag, p), 32'(s_c[1]), 32'(p % e1));
      chk($sformatf("%s_p%0d_d2", tag, p), 32'(s_c[2]), 32'((p / e1) % e2));
      if (p < p1) begin
        for (int g = 1; g < ii; g++) begin
          step();
          chk($sformatf("%s_gap%0d", tag, p), 32'(s_valid), 32'd0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    if_a.flush = 1'b0; if_a.en = 1'b1;
    if_b.flush = 1'b0; if_b.en = 1'b1;
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    chk_st("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_c0", 32'(s_c[0]), 32'd0);
    chk("rst_c1", 32'(s_c[1]), 32'd0);
    chk("rst_c2", 32'(s_c[2]), 32'd0);
    step();
    chk_st("idle", 1'b0, 1'b0, 1'b0);

    // Full default walk: first point one cycle after flush, 4096 back-to-back points.
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    chk_st("t1_start", 1'b0, 1'b1, 1'b0);
    walk(0, 4095, 1, 64, 64, "t1");
    step();
    chk_st("t1_end", 1'b0, 1'b0, 1'b1);
    step(); step();
    chk_st("t1_hold", 1'b0, 1'b0, 1'b1);

    // START_DELAY=3, II=2, 4x2: points at 4,6,..,18 after flush at 0, done at 19.
    sel = 1'b1;
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    chk_st("t2_flush", 1'b0, 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      step();
      chk_st($sformatf("t2_dly%0d", d), 1'b0, 1'b1, 1'b0);
    end
    walk(0, 7, 2, 4, 2, "t2");
    step();
    chk_st("t2_end", 1'b0, 1'b0, 1'b1);

    // Stall of 3 cycles right after (0,1,0); walk resumes at (0,2,0).
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    chk_st("t3_flush", 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    walk(0, 1, 2, 4, 2, "t3a");
    drive(1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk_st($sformatf("t3_stall%0d", s), 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b1);
    step();
    chk("t3_gap", 32'(s_valid), 32'd0);
    walk(2, 7, 2, 4, 2, "t3b");
    step();
    chk_st("t3_end", 1'b0, 1'b0, 1'b1);

    // Flush on the cycle (0,10,3) is due: that point is dropped, walk restarts.
    sel = 1'b0;
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    walk(0, 201, 1, 64, 64, "t4a");
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    chk_st("t4_drop", 1'b0, 1'b1, 1'b0);
    walk(0, 4095, 1, 64, 64, "t4b");
    step();
    chk_st("t4_end", 1'b0, 1'b0, 1'b1);

    // Async reset between edges mid-run.
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    walk(0, 9, 1, 64, 64, "t5a");
    #2 rst_n = 1'b0;
    #1;
    chk_st("t5_rst", 1'b0, 1'b0, 1'b0);
    chk("t5_rst_c1", 32'(s_c[1]), 32'd0);
    #2 rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk_st($sformatf("t5_idle%0d", s), 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1); step(); drive(1'b0, 1'b1);
    walk(0, 3, 1, 64, 64, "t5b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
